// File: rtl/id_fwd_scoreboard.sv
// id_fwd_scoreboard: decode-stage operand hazard unit.
// A per-register counting scoreboard tracks in-flight GPR writes. Operands are
// resolved from the youngest matching producer stage, otherwise from the regfile.
// Decode stalls on a not-ready producer, on a producer that is not visible in any
// forwarding stage, or when the issuing destination's counter is saturated.
module id_fwd_scoreboard #(
   parameter int  NSTAGE = 3,
   parameter int  DATA_W = 32,
   parameter int  NREG   = 32,
   parameter int  CNT_W  = 2,
   localparam int AW     = $clog2(NREG)
) (
   input  logic                     clk,
   input  logic                     resetn,
   input  logic                     ds_valid,
   input  logic                     src1_en,
   input  logic [AW-1:0]            src1_addr,
   input  logic                     src2_en,
   input  logic [AW-1:0]            src2_addr,
   input  logic [DATA_W-1:0]        rf_rdata1,
   input  logic [DATA_W-1:0]        rf_rdata2,
   input  logic                     issue,
   input  logic                     issue_we,
   input  logic [AW-1:0]            issue_dest,
   input  logic [NSTAGE-1:0]        fwd_valid,
   input  logic [NSTAGE-1:0]        fwd_ready,
   input  logic [NSTAGE*AW-1:0]     fwd_dest,
   input  logic [NSTAGE*DATA_W-1:0] fwd_data,
   input  logic                     retire,
   input  logic [AW-1:0]            retire_dest,
   input  logic                     flush,
   output logic [DATA_W-1:0]        src1_value,
   output logic [DATA_W-1:0]        src2_value,
   output logic                     stall,
   output logic [NREG-1:0]          sb_busy,
   output logic                     sb_err,
   output logic [31:0]              stall_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [AW-1:0]    REG_ZERO = {AW{1'b0}};

   typedef struct packed {
      logic              haz;
      logic [DATA_W-1:0] value;
   } res_t;

   logic [CNT_W-1:0] cnt_r [NREG];
   logic [CNT_W-1:0] cnt_src1_s, cnt_src2_s, cnt_dest_s, cnt_ret_s;
   res_t             res1_s, res2_s;
   logic             dest_full_s, stall_s, issue_acc_s, same_reg_s;
   logic             iss_err_s, ret_err_s;
   logic [NREG-1:0]  inc_s, dec_s;

   // Resolve one source: youngest matching stage wins, else scoreboard decides.
   function automatic res_t resolve(
      input logic                     en,
      input logic [AW-1:0]            addr,
      input logic [DATA_W-1:0]        rf,
      input logic                     pending,
      input logic [NSTAGE-1:0]        vld,
      input logic [NSTAGE-1:0]        rdy,
      input logic [NSTAGE*AW-1:0]     dst,
      input logic [NSTAGE*DATA_W-1:0] dat
   );
      res_t r;
      logic found;
      r.haz   = 1'b0;
      r.value = rf;
      found   = 1'b0;
      if (en && (addr != REG_ZERO)) begin
         for (int i = 0; i < NSTAGE; i++) begin
            if (!found && vld[i] && (dst[i*AW +: AW] == addr)) begin
               found = 1'b1;
               if (rdy[i]) begin
                  r.value = dat[i*DATA_W +: DATA_W];
               end else begin
                  r.haz = 1'b1;
               end
            end else begin
               found = found;
            end
         end
         r.haz = found ? r.haz : pending;
      end else begin
         r.haz = 1'b0;
      end
      return r;
   endfunction

   assign cnt_src1_s = cnt_r[src1_addr];
   assign cnt_src2_s = cnt_r[src2_addr];
   assign cnt_dest_s = cnt_r[issue_dest];
   assign cnt_ret_s  = cnt_r[retire_dest];

   // Operand resolution and stall decision (zero-latency combinational path).
   always_comb begin
      res1_s      = resolve(src1_en, src1_addr, rf_rdata1, (cnt_src1_s != CNT_ZERO),
                            fwd_valid, fwd_ready, fwd_dest, fwd_data);
      res2_s      = resolve(src2_en, src2_addr, rf_rdata2, (cnt_src2_s != CNT_ZERO),
                            fwd_valid, fwd_ready, fwd_dest, fwd_data);
      dest_full_s = issue_we && (issue_dest != REG_ZERO) && (cnt_dest_s == CNT_MAX);
      stall_s     = ds_valid && (res1_s.haz || res2_s.haz || dest_full_s);
      src1_value  = res1_s.value;
      src2_value  = res2_s.value;
      stall       = stall_s;
   end

   // Per-register increment/decrement requests and protocol error detection.
   always_comb begin
      issue_acc_s = !stall_s && (cnt_dest_s != CNT_MAX);
      same_reg_s  = issue && issue_we && retire && (issue_dest == retire_dest);
      iss_err_s   = issue && (stall_s || dest_full_s);
      ret_err_s   = retire && (retire_dest != REG_ZERO) && (cnt_ret_s == CNT_ZERO) && !same_reg_s;
      inc_s       = {NREG{1'b0}};
      dec_s       = {NREG{1'b0}};
      for (int r = 1; r < NREG; r++) begin
         if (same_reg_s && (issue_dest == AW'(r))) begin
            inc_s[r] = 1'b0;
            dec_s[r] = 1'b0;
         end else begin
            inc_s[r] = issue && issue_we && (issue_dest == AW'(r)) && issue_acc_s;
            dec_s[r] = retire && (retire_dest == AW'(r)) && (cnt_r[r] != CNT_ZERO);
         end
      end
   end

   // Busy vector: a register is busy while any write to it is in flight.
   always_comb begin
      sb_busy = {NREG{1'b0}};
      for (int r = 0; r < NREG; r++) begin
         sb_busy[r] = (cnt_r[r] != CNT_ZERO);
      end
   end

   // Pending-write counters; flush clears everything and wins over issue/retire.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         for (int r = 0; r < NREG; r++) cnt_r[r] <= CNT_ZERO;
      end else if (flush) begin
         for (int r = 0; r < NREG; r++) cnt_r[r] <= CNT_ZERO;
      end else begin
         cnt_r[0] <= CNT_ZERO;
         for (int r = 1; r < NREG; r++) begin
            if (inc_s[r]) begin
               cnt_r[r] <= cnt_r[r] + CNT_ONE;
            end else if (dec_s[r]) begin
               cnt_r[r] <= cnt_r[r] - CNT_ONE;
            end else begin
               cnt_r[r] <= cnt_r[r];
            end
         end
      end
   end

   // Sticky protocol error: bad retire or illegal issue, ignored in a flush cycle.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         sb_err <= 1'b0;
      end else begin
         sb_err <= sb_err || (!flush && (iss_err_s || ret_err_s));
      end
   end

   // Saturating stall-cycle counter; survives flush.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         stall_cnt <= 32'd0;
      end else if (stall_s && (stall_cnt != 32'hFFFF_FFFF)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end else begin
         stall_cnt <= stall_cnt;
      end
   end

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// Bench for id_fwd_scoreboard: directed scenarios followed by random traffic,
// every cycle checked against a behavioural model of the scoreboard.
module tb_id_fwd_scoreboard;
   localparam int NSTAGE = 3;
   localparam int DW     = 32;
   localparam int NREG   = 32;
   localparam int AW     = 5;
   localparam int CMAX   = 3;

   logic clk = 1'b0;
   logic resetn, ds_valid, src1_en, src2_en, issue, issue_we, retire, flush;
   logic [AW-1:0] src1_addr, src2_addr, issue_dest, retire_dest;
   logic [DW-1:0] rf_rdata1, rf_rdata2, src1_value, src2_value;
   logic [NSTAGE-1:0] fwd_valid, fwd_ready;
   logic [NSTAGE*AW-1:0] fwd_dest;
   logic [NSTAGE*DW-1:0] fwd_data;
   logic stall, sb_err;
   logic [NREG-1:0] sb_busy;
   logic [31:0] stall_cnt;

   int n_cmp = 0;
   int n_bad = 0;

   // model state
   int          m_cnt [NREG];
   logic        m_err;
   logic [31:0] m_scnt;
   logic        exp_stall;

   id_fwd_scoreboard #(.NSTAGE(NSTAGE), .DATA_W(DW), .NREG(NREG), .CNT_W(2)) dut (
      .clk(clk), .resetn(resetn), .ds_valid(ds_valid),
      .src1_en(src1_en), .src1_addr(src1_addr), .src2_en(src2_en), .src2_addr(src2_addr),
      .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
      .issue(issue), .issue_we(issue_we), .issue_dest(issue_dest),
      .fwd_valid(fwd_valid), .fwd_ready(fwd_ready), .fwd_dest(fwd_dest), .fwd_data(fwd_data),
      .retire(retire), .retire_dest(retire_dest), .flush(flush),
      .src1_value(src1_value), .src2_value(src2_value), .stall(stall),
      .sb_busy(sb_busy), .sb_err(sb_err), .stall_cnt(stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic m_reset();
      for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      m_err  = 1'b0;
      m_scnt = 32'd0;
   endtask

   task automatic clr();
      ds_valid = 1'b0; src1_en = 1'b0; src2_en = 1'b0; issue = 1'b0; issue_we = 1'b0;
      retire = 1'b0; flush = 1'b0;
      src1_addr = 5'd0; src2_addr = 5'd0; issue_dest = 5'd0; retire_dest = 5'd0;
      rf_rdata1 = 32'd0; rf_rdata2 = 32'd0;
      fwd_valid = 3'd0; fwd_ready = 3'd0; fwd_dest = 15'd0; fwd_data = 96'd0;
   endtask

   task automatic set_stage(input int i, input logic v, input logic rdy,
                            input logic [AW-1:0] d, input logic [DW-1:0] data);
      fwd_valid[i]        = v;
      fwd_ready[i]        = rdy;
      fwd_dest[i*AW +: AW] = d;
      fwd_data[i*DW +: DW] = data;
   endtask

   // Reference resolution of one operand from the forwarding/scoreboard rules.
   task automatic model_src(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] rf,
                            output logic [DW-1:0] v, output logic h);
      int hit;
      v = rf; h = 1'b0; hit = -1;
      if (en && a != 5'd0) begin
         for (int i = NSTAGE - 1; i >= 0; i--)
            if (fwd_valid[i] && fwd_dest[i*AW +: AW] == a) hit = i;
         if (hit >= 0) begin
            if (fwd_ready[hit]) v = fwd_data[hit*DW +: DW];
            else h = 1'b1;
         end else if (m_cnt[a] != 0) begin
            h = 1'b1;
         end
      end
   endtask

   task automatic check_comb();
      logic [DW-1:0] v1, v2;
      logic h1, h2;
      #1;
      model_src(src1_en, src1_addr, rf_rdata1, v1, h1);
      model_src(src2_en, src2_addr, rf_rdata2, v2, h2);
      exp_stall = ds_valid && (h1 || h2 || (issue_we && issue_dest != 5'd0 && m_cnt[issue_dest] == CMAX));
      check("src1_value", src1_value, v1);
      check("src2_value", src2_value, v2);
      check("stall", 32'(stall), 32'(exp_stall));
   endtask

   task automatic clock_tick();
      logic iss, ret;
      logic [NREG-1:0] b;
      @(posedge clk);
      iss = issue && issue_we && issue_dest != 5'd0;
      ret = retire && retire_dest != 5'd0;
      if (flush) begin
         for (int r = 0; r < NREG; r++) m_cnt[r] = 0;
      end else begin
         if (issue && (exp_stall || (issue_we && issue_dest != 5'd0 && m_cnt[issue_dest] == CMAX)))
            m_err = 1'b1;
         if (!(iss && ret && issue_dest == retire_dest)) begin
            if (ret) begin
               if (m_cnt[retire_dest] > 0) m_cnt[retire_dest]--;
               else m_err = 1'b1;
            end
            if (iss && !exp_stall && m_cnt[issue_dest] < CMAX) m_cnt[issue_dest]++;
         end
      end
      if (exp_stall && m_scnt != 32'hFFFF_FFFF) m_scnt++;
      #1;
      for (int r = 0; r < NREG; r++) b[r] = (m_cnt[r] != 0);
      check("sb_busy", sb_busy, b);
      check("sb_err", 32'(sb_err), 32'(m_err));
      check("stall_cnt", stall_cnt, m_scnt);
   endtask

   task automatic step();
      check_comb();
      clock_tick();
   endtask

   initial begin
      clr();
      m_reset();
      resetn = 1'b0;
      #12;
      check("rst_busy", sb_busy, 32'd0);
      check("rst_err", 32'(sb_err), 32'd0);
      check("rst_stall_cnt", stall_cnt, 32'd0);
      check("rst_stall", 32'(stall), 32'd0);
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;

      // T1: issue r5, then forward ready result from EX
      ds_valid = 1'b1; issue = 1'b1; issue_we = 1'b1; issue_dest = 5'd5;
      step();
      issue = 1'b0; issue_we = 1'b0;
      src1_en = 1'b1; src1_addr = 5'd5; rf_rdata1 = 32'h1111;
      set_stage(0, 1'b1, 1'b1, 5'd5, 32'h1234);
      check_comb();
      check("t1_src1", src1_value, 32'h1234);
      check("t1_stall", 32'(stall), 32'd0);
      clock_tick();

      // T2: not-ready producer stalls, then becomes visible and ready in stage1
      clr(); ds_valid = 1'b1;
      src2_en = 1'b1; src2_addr = 5'd7; rf_rdata2 = 32'h7777;
      set_stage(0, 1'b1, 1'b0, 5'd7, 32'h0);
      check_comb();
      check("t2_stall", 32'(stall), 32'd1);
      clock_tick();
      check("t2_stall_cnt", stall_cnt, 32'd1);
      set_stage(0, 1'b0, 1'b0, 5'd0, 32'h0);
      set_stage(1, 1'b1, 1'b1, 5'd7, 32'hDEAD);
      check_comb();
      check("t2_src2", src2_value, 32'hDEAD);
      check("t2_unstall", 32'(stall), 32'd0);
      clock_tick();

      // T3: youngest stage wins
      clr(); ds_valid = 1'b1; src1_en = 1'b1; src1_addr = 5'd3;
      set_stage(0, 1'b1, 1'b1, 5'd3, 32'hA);
      set_stage(2, 1'b1, 1'b1, 5'd3, 32'hB);
      check_comb();
      check("t3_src1", src1_value, 32'hA);
      clock_tick();

      // T4: register 0 is never forwarded or counted
      clr(); ds_valid = 1'b1; src1_en = 1'b1; src1_addr = 5'd0;
      set_stage(0, 1'b1, 1'b1, 5'd0, 32'h55);
      issue = 1'b1; issue_we = 1'b1; issue_dest = 5'd0;
      check_comb();
      check("t4_src1", src1_value, 32'h0);
      check("t4_stall", 32'(stall), 32'd0);
      clock_tick();
      check("t4_busy0", 32'(sb_busy[0]), 32'd0);
      check("t4_err", 32'(sb_err), 32'd0);

      // retire of r4 with nothing pending raises the sticky error
      clr(); retire = 1'b1; retire_dest = 5'd4;
      step();
      check("t6_err", 32'(sb_err), 32'd1);

      // T5: saturate r9, then saturation stall and cancelling issue+retire
      clr(); ds_valid = 1'b1; issue = 1'b1; issue_we = 1'b1; issue_dest = 5'd9;
      for (int k = 0; k < 3; k++) step();
      check("t5_busy9", 32'(sb_busy[9]), 32'd1);
      issue = 1'b0;
      check_comb();
      check("t5_full_stall", 32'(stall), 32'd1);
      clock_tick();
      issue = 1'b1; retire = 1'b1; retire_dest = 5'd9;
      step();
      issue = 1'b0; retire = 1'b0;
      check_comb();
      check("t5_still_full", 32'(stall), 32'd1);
      clock_tick();

      // T6: flush clears counts, stall_cnt survives
      clr(); flush = 1'b1;
      step();
      check("t6_flush_busy", sb_busy, 32'd0);
      check("t6_scnt_kept", 32'(stall_cnt != 32'd0), 32'd1);

      // T6: asynchronous reset in the middle of a stall
      clr(); ds_valid = 1'b1; src1_en = 1'b1; src1_addr = 5'd6;
      set_stage(0, 1'b1, 1'b0, 5'd6, 32'h0);
      issue = 1'b1; issue_we = 1'b1; issue_dest = 5'd6;
      check_comb();
      clock_tick();
      resetn = 1'b0;
      #1;
      m_reset();
      check("mid_rst_busy", sb_busy, 32'd0);
      check("mid_rst_err", 32'(sb_err), 32'd0);
      check("mid_rst_scnt", stall_cnt, 32'd0);
      check("mid_rst_stall_comb", 32'(stall), 32'd1);
      clr();
      @(negedge clk) resetn = 1'b1;
      @(posedge clk); #1;

      // random traffic over a small register window so counters saturate
      for (int n = 0; n < 600; n++) begin
         ds_valid    = 1'($urandom_range(0, 3) != 0);
         src1_en     = 1'($urandom_range(0, 1));
         src1_addr   = 5'($urandom_range(0, 7));
         src2_en     = 1'($urandom_range(0, 1));
         src2_addr   = 5'($urandom_range(0, 7));
         rf_rdata1   = $urandom;
         rf_rdata2   = $urandom;
         for (int i = 0; i < NSTAGE; i++)
            set_stage(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
                      5'($urandom_range(0, 7)), $urandom);
         issue       = 1'($urandom_range(0, 1));
         issue_we    = 1'($urandom_range(0, 3) != 0);
         issue_dest  = 5'($urandom_range(0, 7));
         retire      = 1'($urandom_range(0, 2) == 0);
         retire_dest = 5'($urandom_range(0, 7));
         flush       = 1'($urandom_range(0, 31) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
